dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 2, legal range 1..15: clock edges from request acceptance to resp_valid high.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  1  CPU presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address; word index = req_addr[31:2].
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  byte enables for stores; bit i selects bits 8i+7:8i.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  CPU consumes the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 States: IDLE, WAIT, RESP.
REQ-016 Acceptance occurs on an edge where req_valid=1 and req_ready=1; req_ready is 1 only in IDLE.
REQ-017 On acceptance, latch req_we, word index, req_wdata, req_be; load latency counter with LATENCY-1.
REQ-018 IDLE -> WAIT on acceptance when LATENCY>1; IDLE -> RESP on acceptance when LATENCY=1.
REQ-019 WAIT: counter decrements each edge; WAIT -> RESP on the edge where the counter equals 1.
REQ-020 resp_valid is 1 exactly in RESP, so it first rises LATENCY edges after the accepting edge.
REQ-021 RESP -> IDLE on an edge with resp_ready=1; otherwise RESP holds with resp_rdata and resp_err stable.
REQ-022 Back-to-back: no new request is accepted on the RESP -> IDLE edge; the earliest next acceptance is the following edge.
REQ-023 Error: resp_err=1 when latched addr[1:0]!=0 or word index >= DEPTH_WORDS; an errored store writes nothing; resp_rdata=0.
REQ-024 Store commit: performed on the edge entering RESP; only bytes with be=1 change; be=4'b0000 is a legal no-op store acknowledged with resp_err=0.
REQ-025 Load data: full word read from the array on the edge entering RESP, registered into resp_rdata; req_be ignored for loads.
REQ-026 A load issued after a store to the same word returns the stored data (store committed before next acceptance).
REQ-027 Inputs req_* are ignored outside IDLE; changes there have no effect.
REQ-028 Address arithmetic: word index uses req_addr[31:2] compared in full 30-bit width, with no truncation or wrap to DEPTH_WORDS.

Reset
REQ-029 With rst=1 at an edge: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0; req_ready=1 from the following cycle.
REQ-030 Reset in WAIT aborts the request with no store commit and no response.
REQ-031 Reset in RESP drops the pending response; a store already committed remains.
REQ-032 Memory array contents are not cleared by reset.
REQ-033 rst has priority over every other input on the same edge.

Verification
REQ-034 Store then load (LATENCY=2): store addr 0x10, data 0xDEADBEEF, be=1111 -> resp_valid 2 edges later, err=0; load 0x10 -> rdata 0xDEADBEEF.
REQ-035 Partial store: over 0xDEADBEEF, store 0x000000AA with be=0001 to 0x10 -> later load returns 0xDEADBEAA.
REQ-036 Errors: load 0x13 -> err=1, rdata=0; store to 0x400 (DEPTH 256) -> err=1, and a later load of word 0 is unchanged.
REQ-037 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, rdata, err stable; req_ready=0 throughout; release -> IDLE next edge.
REQ-038 Reset mid-operation: accept store 0x55555555 to 0x20, assert rst in WAIT -> no response; load 0x20 returns its prior value.
REQ-039 LATENCY=1 build: accept load -> resp_valid on the very next cycle; with resp_ready tied 1, sustained throughput is one request per 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, answers a fixed
// LATENCY edges later, with byte-enable stores and alignment/range error reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [30:0] DEPTH_L  = 31'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rerr_q, rerr_d;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            req_err_s;
    logic            enter_resp_s;
    logic            commit_s;
    logic            cur_we_s;
    logic            cur_err_s;
    logic [AW-1:0]   cur_idx_s;
    logic [31:0]     cur_wdata_s;
    logic [3:0]      cur_be_s;
    logic [31:0]     commit_word_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Error check uses the full 30-bit word index so high address bits never alias into range.
    assign req_err_s = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr[31:2]} >= DEPTH_L);

    // Next-state, request latching and response capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        err_d        = err_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rdata_d      = rdata_q;
        rerr_d       = rerr_q;
        enter_resp_s = 1'b0;
        cur_we_s     = we_q;
        cur_err_s    = err_q;
        cur_idx_s    = idx_q;
        cur_wdata_s  = wdata_q;
        cur_be_s     = be_q;

        case (state_q)
            IDLE: begin
                // A LATENCY=1 request is committed on its own accepting edge, straight from the inputs.
                cur_we_s    = req_we;
                cur_err_s   = req_err_s;
                cur_idx_s   = req_addr[AW+1:2];
                cur_wdata_s = req_wdata;
                cur_be_s    = req_be;
                if (req_valid) begin
                    we_d    = req_we;
                    err_d   = req_err_s;
                    idx_d   = req_addr[AW+1:2];
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = LAT_INIT;
                    if (LATENCY == 1) begin
                        state_d      = RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d      = RESP;
                    enter_resp_s = 1'b1;
                    cnt_d        = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (enter_resp_s) begin
            rerr_d  = cur_err_s;
            rdata_d = (!cur_we_s && !cur_err_s) ? mem_q[cur_idx_s] : 32'd0;
        end else begin
            rerr_d  = rerr_q;
            rdata_d = rdata_q;
        end
    end

    assign commit_s      = enter_resp_s && cur_we_s && !cur_err_s && !rst;
    assign commit_word_s = merge_bytes(mem_q[cur_idx_s], cur_wdata_s, cur_be_s);

    // Control and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_q[cur_idx_s] <= commit_word_s;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = rerr_q;
endmodule
